// File: rtl/sar_adc_pkg.sv
// Shared types and constants for the SAR ADC controller.
// Optional comparator synchronizer is enabled by SAR_ADC_CMP_SYNC_EN.
package sar_adc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        SETTLE,
        DECIDE,
        DONE
    } state_t;

    localparam int SYNC_DEPTH = 2;

    function automatic bit params_ok(input int width, input int sample_cycles,
                                     input int settle_cycles);
        return (width >= 2) && (sample_cycles >= 1) && (settle_cycles >= 0);
    endfunction

endpackage

// File: rtl/sar_adc_ctrl_cmp_sync.sv
// Multi-flop synchronizer for the asynchronous comparator decision.
// Only present when SAR_ADC_CMP_SYNC_EN is defined.
`ifdef SAR_ADC_CMP_SYNC_EN
module cmp_sync
    import sar_adc_pkg::*;
#(
    parameter int DEPTH = SYNC_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d_i};
        end
    end

    assign q_o = sync_q[DEPTH-1];

endmodule
`endif

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: samples, walks the DAC code MSB first, returns a result.
// Define SAR_ADC_CMP_SYNC_EN to synchronize cmp_in and extend each settle wait accordingly.
//
//   state  | meaning
//   IDLE   | waiting for start, dac_code = 0
//   SAMPLE | track switch closed for SAMPLE_CYCLES
//   SETTLE | trial code on the DAC, waiting for the comparator
//   DECIDE | resolve bit idx, set up the next trial
//   DONE   | result loaded, done pulse
module sar_adc_ctrl
    import sar_adc_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_in,
    output logic             sample_o,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             valid
);

`ifdef SAR_ADC_CMP_SYNC_EN
    localparam int W_SETTLE = SETTLE_CYCLES + SYNC_DEPTH;
`else
    localparam int W_SETTLE = SETTLE_CYCLES;
`endif
    localparam int CNT_MAX = (SAMPLE_CYCLES > W_SETTLE) ? SAMPLE_CYCLES : W_SETTLE;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = $clog2(WIDTH);

    localparam logic [CW-1:0]    SAMPLE_LOAD = CW'(SAMPLE_CYCLES - 1);
    localparam logic [CW-1:0]    SETTLE_LOAD = (W_SETTLE > 0) ? CW'(W_SETTLE - 1) : '0;
    localparam logic [WIDTH-1:0] MIDSCALE    = {1'b1, {(WIDTH-1){1'b0}}};
    // With no settle wait each trial goes straight to its decision.
    localparam state_t           BIT_ENTRY   = (W_SETTLE > 0) ? SETTLE : DECIDE;

    if (!params_ok(WIDTH, SAMPLE_CYCLES, SETTLE_CYCLES)) begin : g_param_err
        $error("sar_adc_ctrl: WIDTH must be >= 2 and SAMPLE_CYCLES >= 1");
    end

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] sar_q;
    logic [WIDTH-1:0] sar_d;
    logic [WIDTH-1:0] dac_q;
    logic [WIDTH-1:0] result_q;
    logic             sample_q;
    logic             busy_q;
    logic             done_q;
    logic             valid_q;
    logic             cmp_eff;

`ifdef SAR_ADC_CMP_SYNC_EN
    cmp_sync #(
        .DEPTH(SYNC_DEPTH)
    ) u_cmp_sync (
        .clk(clk),
        .rst(rst),
        .d_i(cmp_in),
        .q_o(cmp_eff)
    );
`else
    assign cmp_eff = cmp_in;
`endif

    // The trial bit is already 1, so writing the decision clears or keeps it.
    always_comb begin
        sar_d        = sar_q;
        sar_d[idx_q] = cmp_eff;
        if (idx_q != '0) begin
            sar_d[idx_q - IW'(1)] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            sar_q    <= '0;
            dac_q    <= '0;
            result_q <= '0;
            sample_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= SAMPLE;
                        cnt_q    <= SAMPLE_LOAD;
                        sar_q    <= '0;
                        valid_q  <= 1'b0;
                        sample_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                SAMPLE: begin
                    if (cnt_q == '0) begin
                        state_q  <= BIT_ENTRY;
                        cnt_q    <= SETTLE_LOAD;
                        idx_q    <= IW'(WIDTH - 1);
                        sar_q    <= MIDSCALE;
                        dac_q    <= MIDSCALE;
                        sample_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        state_q <= DECIDE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DECIDE: begin
                    sar_q <= sar_d;
                    dac_q <= sar_d;
                    if (idx_q != '0) begin
                        idx_q   <= idx_q - IW'(1);
                        cnt_q   <= SETTLE_LOAD;
                        state_q <= BIT_ENTRY;
                    end else begin
                        state_q  <= DONE;
                        result_q <= sar_d;
                        done_q   <= 1'b1;
                        valid_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    dac_q   <= '0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sample_o = sample_q;
    assign dac_code = dac_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Scoreboard bench for sar_adc_ctrl with an ideal comparator driven from dac_code.
// Honours SAR_ADC_CMP_SYNC_EN for the expected settle length.
module tb_sar_adc_ctrl;

    localparam int WIDTH  = 8;
    localparam int S      = 4;
    localparam int SETTLE = 1;
`ifdef SAR_ADC_CMP_SYNC_EN
    localparam int W = SETTLE + 2;
`else
    localparam int W = SETTLE;
`endif
    localparam int LAT = S + WIDTH * (W + 1) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             cmp_in;
    logic             sample_o;
    logic [WIDTH-1:0] dac_code;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             valid;
    logic [WIDTH-1:0] vin = '0;

    sar_adc_ctrl #(
        .WIDTH(WIDTH),
        .SAMPLE_CYCLES(S),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .cmp_in(cmp_in),
        .sample_o(sample_o),
        .dac_code(dac_code),
        .busy(busy),
        .done(done),
        .result(result),
        .valid(valid)
    );

    assign cmp_in = (vin >= dac_code);

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int               done_cyc;
        logic [WIDTH-1:0] res;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Binary search over the code range: the trial presented for bit k.
    function automatic logic [WIDTH-1:0] trial(input logic [WIDTH-1:0] v, input int k);
        int code;
        int t;
        code = 0;
        for (int i = 0; i < k; i++) begin
            t = code + (1 << (WIDTH - 1 - i));
            if (int'(v) >= t) code = t;
        end
        return WIDTH'(code + (1 << (WIDTH - 1 - k)));
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done result=%0h (cycle %0d)", result, cyc);
            end else begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("done_cycle", cyc, e.done_cyc);
                chk("valid_at_done", valid, 1);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_sample"}, sample_o, 0);
        chk({tag, "_dac"}, dac_code, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_valid"}, valid, 0);
    endtask

    // Called just after a negedge with the DUT idle; returns at a negedge in IDLE.
    task automatic convert(input logic [WIDTH-1:0] v, input bit busy_pulses, input int rst_at);
        int e;
        int k;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        vin   = v;
        start = 1'b1;
        e     = cyc + 1;
        if (rst_at == 0) sb.push_back('{e + LAT - 1, v});
        for (int p = 1; p <= LAT + 1; p++) begin
            @(negedge clk);
            start = busy_pulses && (p == 5 || p == 15);
            if (rst_at != 0 && p == rst_at + 1) begin
                check_all_zero("mid_reset");
                rst = 1'b0;
                return;
            end
            chk("sample_window", sample_o, (p <= S));
            chk("busy", busy, (p <= LAT));
            if (p == 1) chk("valid_cleared_on_start", valid, 0);
            if (p <= S || p == LAT + 1) chk("dac_zero", dac_code, 0);
            if (p > S && p < LAT && ((p - S) % (W + 1)) == 0) begin
                k = (p - S) / (W + 1) - 1;
                chk("trial_code", dac_code, trial(v, k));
            end
            if (p == LAT + 1) begin
                chk("done_one_cycle", done, 0);
                chk("result_held", result, v);
                chk("valid_held", valid, 1);
                chk("scoreboard_drained", sb.size(), 0);
            end
            if (rst_at != 0 && p == rst_at) rst = 1'b1;
        end
        sb.delete();
    endtask

    task automatic back_to_back(input logic [WIDTH-1:0] v);
        int e;
        vin   = v;
        start = 1'b1;
        e     = cyc + 1;
        sb.push_back('{e + LAT - 1, v});
        sb.push_back('{e + 2 * LAT, v});
        repeat (LAT + 3) @(negedge clk);
        start = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        chk("b2b_drained", sb.size(), 0);
        chk("b2b_idle", busy, 0);
        sb.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("idle_after_reset");

        convert(8'hA5, 1'b0, 0);
        convert(8'hFF, 1'b0, 0);
        convert(8'h00, 1'b0, 0);
        convert(8'h3C, 1'b0, 0);
        convert(WIDTH'($urandom), 1'b1, 0);
        convert(WIDTH'($urandom), 1'b0, 10);
        convert(WIDTH'($urandom), 1'b0, 0);
        back_to_back(WIDTH'($urandom));
        for (int n = 0; n < 10; n++) begin
            convert(WIDTH'($urandom), 1'($urandom_range(0, 1)), 0);
        end
        convert(8'h01, 1'b0, 0);
        convert(8'h80, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout cycle=%0d limit_reached", cyc);
        $fatal(1, "timeout");
    end

endmodule
